// File: rtl/bpm_estimator_if.sv
// Purpose: tempo bus between the audio beat detector and the filter-stack controller.
// Latency: n/a (signal bundle only).
// Backpressure: none; beat_in is a raw level, the outputs are free-running pulses/levels.
interface bpm_estimator_if #(
   parameter int W = 8
);
   logic         beat_in;
   logic         beat_detected;
   logic [W-1:0] BPM_estimate;
   logic         bpm_update;

   // Estimator side: consumes the onset, produces beat and tempo.
   modport master (
      input  beat_in,
      output beat_detected,
      output BPM_estimate,
      output bpm_update
   );

   // Environment side: drives the onset, observes beat and tempo.
   modport slave (
      output beat_in,
      input  beat_detected,
      input  BPM_estimate,
      input  bpm_update
   );
endinterface

// File: rtl/bpm_estimator.sv
// Purpose: edge-detect onsets, gate them with a refractory window, measure the
//          inter-beat interval in ms and divide 60000 by it to get BPM.
// Latency: beat_detected 1 cycle after the rise; BPM_estimate/bpm_update 17 cycles after it.
// Backpressure: none; rises arriving while dividing or inside the refractory window are dropped.
// Optional feature: define BPM_SMOOTHING_EN for a 3:1 running average of the estimate.
module bpm_estimator #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int MAX_BPM     = 240,
   parameter int MIN_BPM     = 40
) (
   input logic           clk,
   input logic           reset,
   bpm_estimator_if.master bus
);

   localparam int unsigned PRESC_N    = CLK_FREQ_HZ / 1000;
   localparam int          PW         = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
   localparam logic [PW-1:0] PRESC_TC = PW'(PRESC_N - 1);
   localparam int          BW         = $clog2(MAX_BPM + 1);
   localparam logic [15:0] REFRACT_MS = 16'(60000 / MAX_BPM);
   localparam logic [15:0] TIMEOUT_MS = 16'(60000 / MIN_BPM);
   localparam logic [15:0] DIVIDEND   = 16'd60000;
   localparam logic [15:0] MAX_Q      = 16'(MAX_BPM);

   typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

   state_t         state;
   logic [PW-1:0]  presc;
   logic [15:0]    ms_cnt;
   logic           beat_q;
   logic           tick;
   logic           rise;
   logic           timeout_hit;
   logic           accept;

   logic [15:0]    div_d;
   logic [15:0]    div_q;
   logic [15:0]    div_r;
   logic [3:0]     iter;
   logic [16:0]    r_sh;
   logic           r_ge;
   logic [15:0]    r_nx;
   logic [15:0]    q_nx;
   logic [15:0]    q_sat;
   logic [BW-1:0]  q_clamp;
   logic [BW-1:0]  bpm_new;

   logic           beat_det_r;
   logic           bpm_upd_r;
   logic [BW-1:0]  bpm_r;

   assign tick = (presc == PRESC_TC);
   assign rise = bus.beat_in & ~beat_q;

   // Timeout fires in the tick cycle that would carry ms_cnt onto TIMEOUT_MS,
   // so the zero estimate appears in the same cycle ms_cnt reads TIMEOUT_MS.
   assign timeout_hit = (state == MEASURE) &&
                        ((tick && (ms_cnt == TIMEOUT_MS - 16'd1)) || (ms_cnt >= TIMEOUT_MS));

   // A timeout beats a coincident rise; rises during DIVIDE always lie inside the refractory window.
   assign accept = rise && ((state == IDLE) ||
                            ((state == MEASURE) && !timeout_hit && (ms_cnt >= REFRACT_MS)));

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      r_sh = {div_r, div_q[15]};
      r_ge = (r_sh >= {1'b0, div_d});
      r_nx = r_ge ? 16'(r_sh - {1'b0, div_d}) : r_sh[15:0];
      q_nx = {div_q[14:0], r_ge};
   end

   // Clamp on the full 16-bit quotient, narrow only afterwards.
   assign q_sat   = (q_nx > MAX_Q) ? MAX_Q : q_nx;
   assign q_clamp = BW'(q_sat);

`ifdef BPM_SMOOTHING_EN
   logic [9:0] smooth_sum;
   assign smooth_sum = 10'(bpm_r) * 10'd3 + 10'(q_clamp);
   assign bpm_new    = (div_d == 16'd0) ? '0 :
                       (bpm_r == '0)    ? q_clamp : BW'(smooth_sum >> 2);
`else
   assign bpm_new    = (div_d == 16'd0) ? '0 : q_clamp;
`endif

   // Onset edge detector register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) beat_q <= 1'b0;
      else       beat_q <= bus.beat_in;
   end

   // Millisecond prescaler and saturating ms counter, restarted by each accepted beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc  <= '0;
         ms_cnt <= '0;
      end else if (accept) begin
         presc  <= '0;
         ms_cnt <= '0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick && (ms_cnt != 16'hFFFF)) ms_cnt <= ms_cnt + 16'd1;
      end
   end

   // Control FSM with the divider datapath and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         div_d      <= '0;
         div_q      <= '0;
         div_r      <= '0;
         iter       <= '0;
         beat_det_r <= 1'b0;
         bpm_upd_r  <= 1'b0;
         bpm_r      <= '0;
      end else begin
         beat_det_r <= 1'b0;
         bpm_upd_r  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  beat_det_r <= 1'b1;
                  state      <= MEASURE;
               end
            end
            MEASURE: begin
               if (timeout_hit) begin
                  bpm_r     <= '0;
                  bpm_upd_r <= 1'b1;
                  state     <= IDLE;
               end else if (accept) begin
                  beat_det_r <= 1'b1;
                  div_d      <= ms_cnt;
                  div_q      <= DIVIDEND;
                  div_r      <= '0;
                  iter       <= '0;
                  state      <= DIVIDE;
               end
            end
            DIVIDE: begin
               div_q <= q_nx;
               div_r <= r_nx;
               iter  <= iter + 4'd1;
               if (iter == 4'd15) begin
                  bpm_r     <= bpm_new;
                  bpm_upd_r <= 1'b1;
                  state     <= MEASURE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.beat_detected = beat_det_r;
   assign bus.bpm_update    = bpm_upd_r;
   assign bus.BPM_estimate  = bpm_r;

endmodule
